// File: rtl/warp_mem_arbiter.sv
// Round-robin arbiter sharing one memory request port between all warps of an SM.
// Tracks per-warp outstanding requests, routes responses by tag and drives the memory stall mask.
module warp_mem_arbiter #(
    parameter int NUM_WARPS       = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_WARPS-1:0]        req_valid,
    input  logic [NUM_WARPS*ADDR_W-1:0] req_addr,
    input  logic [NUM_WARPS-1:0]        req_write,
    output logic [NUM_WARPS-1:0]        req_ready,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [ADDR_W-1:0]           mem_req_addr,
    output logic                        mem_req_write,
    output logic [5:0]                  mem_req_tag,
    input  logic                        mem_resp_valid,
    input  logic [5:0]                  mem_resp_tag,
    output logic                        resp_valid,
    output logic [5:0]                  resp_warp_id,
    output logic [NUM_WARPS-1:0]        warp_stall_mask,
    output logic                        stall_valid,
    output logic [5:0]                  stall_warp_id,
    output logic                        err_underflow
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = $clog2(NUM_WARPS);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0]     cnt_q [NUM_WARPS];
    logic [CNT_W-1:0]     cnt_d [NUM_WARPS];
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     grant_idx;
    logic [NUM_WARPS-1:0] eligible;
    logic [NUM_WARPS-1:0] inc_v;
    logic [NUM_WARPS-1:0] dec_v;
    logic [NUM_WARPS-1:0] mask_d;
    logic                 slot_free;
    logic                 grant_any;
    logic                 resp_known;
    logic                 new_stall;
    logic                 underflow;

    assign slot_free = !mem_req_valid || mem_req_ready;

    // NOTE: combinational blocks use blocking assignments with every output defaulted first, so no latch is inferred.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        eligible  = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            eligible[w] = req_valid[w] && (cnt_q[w] < MAX_CNT);
        end
        if (slot_free) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                idx = int'(rr_ptr) + i;
                if (idx >= NUM_WARPS) idx = idx - NUM_WARPS;
                if (!grant_any && eligible[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = PTR_W'(idx);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_any) req_ready[grant_idx] = 1'b1;
    end

    // A response only decrements a counter that is non-zero; anything else is an underflow.
    always_comb begin
        inc_v      = '0;
        dec_v      = '0;
        mask_d     = '0;
        resp_known = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            inc_v[w]   = grant_any && (grant_idx == PTR_W'(w));
            dec_v[w]   = mem_resp_valid && (mem_resp_tag == 6'(w)) && (cnt_q[w] != '0);
            resp_known = resp_known | dec_v[w];
            cnt_d[w]   = cnt_q[w];
            if (inc_v[w] && !dec_v[w]) cnt_d[w] = cnt_q[w] + CNT_W'(1);
            else if (dec_v[w] && !inc_v[w]) cnt_d[w] = cnt_q[w] - CNT_W'(1);
            mask_d[w]  = (cnt_d[w] != '0);
        end
    end

    assign new_stall = grant_any && (cnt_q[grant_idx] == '0);
    assign underflow = mem_resp_valid && !resp_known;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the counter array is reset explicitly; it is control state, not a RAM.
            for (int w = 0; w < NUM_WARPS; w++) cnt_q[w] <= '0;
            rr_ptr          <= '0;
            mem_req_valid   <= 1'b0;
            mem_req_addr    <= '0;
            mem_req_write   <= 1'b0;
            mem_req_tag     <= '0;
            resp_valid      <= 1'b0;
            resp_warp_id    <= '0;
            warp_stall_mask <= '0;
            stall_valid     <= 1'b0;
            stall_warp_id   <= '0;
            err_underflow   <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) cnt_q[w] <= cnt_d[w];
            warp_stall_mask <= mask_d;
            if (slot_free) begin
                mem_req_valid <= grant_any;
                if (grant_any) begin
                    mem_req_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                    mem_req_write <= req_write[grant_idx];
                    mem_req_tag   <= 6'(grant_idx);
                end
            end
            if (grant_any) begin
                rr_ptr <= (grant_idx == PTR_W'(NUM_WARPS - 1)) ? '0 : grant_idx + PTR_W'(1);
            end
            stall_valid <= new_stall;
            if (new_stall) stall_warp_id <= 6'(grant_idx);
            resp_valid   <= mem_resp_valid;
            resp_warp_id <= mem_resp_tag;
            if (underflow) err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_warp_mem_arbiter.sv
// Self-checking bench for warp_mem_arbiter: vector table, directed corner sequences and a
// random phase, all checked against a cycle model with a scoreboard of expected memory requests.
module tb_warp_mem_arbiter;

    localparam int NW   = 8;
    localparam int MAXO = 4;
    localparam int AW   = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NW-1:0]     req_valid;
    logic [NW*AW-1:0]  req_addr;
    logic [NW-1:0]     req_write;
    logic [NW-1:0]     req_ready;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [AW-1:0]     mem_req_addr;
    logic              mem_req_write;
    logic [5:0]        mem_req_tag;
    logic              mem_resp_valid;
    logic [5:0]        mem_resp_tag;
    logic              resp_valid;
    logic [5:0]        resp_warp_id;
    logic [NW-1:0]     warp_stall_mask;
    logic              stall_valid;
    logic [5:0]        stall_warp_id;
    logic              err_underflow;

    warp_mem_arbiter #(.NUM_WARPS(NW), .MAX_OUTSTANDING(MAXO), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write), .req_ready(req_ready),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_write(mem_req_write), .mem_req_tag(mem_req_tag),
        .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag),
        .resp_valid(resp_valid), .resp_warp_id(resp_warp_id),
        .warp_stall_mask(warp_stall_mask), .stall_valid(stall_valid), .stall_warp_id(stall_warp_id),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]    tag;
        logic [AW-1:0] addr;
        logic          write;
    } mreq_t;

    typedef struct {
        logic [NW-1:0] rv;
        logic          rdy;
        logic          respv;
        logic [5:0]    tag;
        logic [NW-1:0] exp_ready;
        logic [NW-1:0] exp_mask;
    } vec_t;

    mreq_t mem_q[$];
    vec_t  tbl[12];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (registered view of the DUT).
    int    m_cnt[NW];
    int    m_rr    = 0;
    logic  m_valid = 1'b0;
    logic  m_err   = 1'b0;
    logic  m_rv    = 1'b0;
    logic  [5:0] m_rid = '0;
    logic  m_sv    = 1'b0;
    logic  [5:0] m_sid = '0;
    logic  g;
    int    gw;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NW-1:0] model_mask();
        logic [NW-1:0] m;
        m = '0;
        for (int w = 0; w < NW; w++) m[w] = (m_cnt[w] != 0);
        return m;
    endfunction

    // Drive one cycle of inputs, then compare DUT outputs with the model.
    task automatic apply(input logic rst, input logic [NW-1:0] rv, input logic [NW-1:0] rw,
                         input logic rdy, input logic respv, input logic [5:0] tag);
        logic [NW-1:0] exp_ready;
        @(negedge clk);
        rst_n          = rst;
        req_valid      = rv;
        req_write      = rw;
        mem_req_ready  = rdy;
        mem_resp_valid = respv;
        mem_resp_tag   = tag;
        for (int w = 0; w < NW; w++) req_addr[w*AW +: AW] = $urandom();
        #1;
        g  = 1'b0;
        gw = 0;
        if (!m_valid || rdy) begin
            for (int i = 0; i < NW; i++) begin
                int idx;
                idx = (m_rr + i) % NW;
                if (!g && rv[idx] && m_cnt[idx] < MAXO) begin
                    g  = 1'b1;
                    gw = idx;
                end
            end
        end
        exp_ready = '0;
        if (g) exp_ready[gw] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("mem_req_valid", 64'(mem_req_valid), 64'(m_valid));
        if (m_valid) begin
            if (mem_q.size() == 0) begin
                check("mem_q_empty", 64'(mem_req_valid), 64'(0));
            end else begin
                check("mem_req_tag", 64'(mem_req_tag), 64'(mem_q[0].tag));
                check("mem_req_addr", 64'(mem_req_addr), 64'(mem_q[0].addr));
                check("mem_req_write", 64'(mem_req_write), 64'(mem_q[0].write));
            end
        end
        check("resp_valid", 64'(resp_valid), 64'(m_rv));
        if (m_rv) check("resp_warp_id", 64'(resp_warp_id), 64'(m_rid));
        check("stall_mask", 64'(warp_stall_mask), 64'(model_mask()));
        check("stall_valid", 64'(stall_valid), 64'(m_sv));
        if (m_sv) check("stall_warp_id", 64'(stall_warp_id), 64'(m_sid));
        check("err_underflow", 64'(err_underflow), 64'(m_err));
    endtask

    // Advance the model across the active edge using the inputs driven by apply().
    task automatic commit();
        logic dec;
        @(posedge clk);
        if (!rst_n) begin
            for (int w = 0; w < NW; w++) m_cnt[w] = 0;
            m_rr = 0; m_valid = 1'b0; m_err = 1'b0; m_rv = 1'b0; m_sv = 1'b0;
            mem_q.delete();
        end else begin
            if (m_valid && mem_req_ready) void'(mem_q.pop_front());
            if (!m_valid || mem_req_ready) m_valid = g;
            if (g) mem_q.push_back('{tag: 6'(gw), addr: req_addr[gw*AW +: AW], write: req_write[gw]});
            m_sv = g && (m_cnt[gw] == 0);
            if (g) m_sid = 6'(gw);
            m_rv  = mem_resp_valid;
            m_rid = mem_resp_tag;
            dec = 1'b0;
            if (mem_resp_valid) begin
                if (int'(mem_resp_tag) < NW && m_cnt[mem_resp_tag] > 0) dec = 1'b1;
                else m_err = 1'b1;
            end
            if (dec) m_cnt[mem_resp_tag] = m_cnt[mem_resp_tag] - 1;
            if (g) begin
                m_cnt[gw] = m_cnt[gw] + 1;
                m_rr = (gw + 1) % NW;
            end
        end
    endtask

    task automatic step(input logic rst, input logic [NW-1:0] rv, input logic [NW-1:0] rw,
                        input logic rdy, input logic respv, input logic [5:0] tag);
        apply(rst, rv, rw, rdy, respv, tag);
        commit();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int w = 0; w < NW; w++) m_cnt[w] = 0;
        rst_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_tag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
        check("rst_mem_req_addr", 64'(mem_req_addr), 64'(0));
        check("rst_mem_req_tag", 64'(mem_req_tag), 64'(0));
        check("rst_stall_mask", 64'(warp_stall_mask), 64'(0));
        check("rst_err", 64'(err_underflow), 64'(0));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));

        // Single request, backpressure on warp 5 then warp 0, responses.
        //          rv     rdy   respv  tag    ready  mask
        tbl[0]  = '{8'h04, 1'b1, 1'b0, 6'd0, 8'h04, 8'h00};
        tbl[1]  = '{8'h00, 1'b1, 1'b0, 6'd0, 8'h00, 8'h04};
        tbl[2]  = '{8'h20, 1'b1, 1'b0, 6'd0, 8'h20, 8'h04};
        tbl[3]  = '{8'h21, 1'b0, 1'b0, 6'd0, 8'h00, 8'h24};
        tbl[4]  = '{8'h21, 1'b0, 1'b0, 6'd0, 8'h00, 8'h24};
        tbl[5]  = '{8'h21, 1'b0, 1'b0, 6'd0, 8'h00, 8'h24};
        tbl[6]  = '{8'h21, 1'b0, 1'b0, 6'd0, 8'h00, 8'h24};
        tbl[7]  = '{8'h21, 1'b1, 1'b0, 6'd0, 8'h01, 8'h24};
        tbl[8]  = '{8'h00, 1'b1, 1'b1, 6'd5, 8'h00, 8'h25};
        tbl[9]  = '{8'h00, 1'b1, 1'b1, 6'd0, 8'h00, 8'h05};
        tbl[10] = '{8'h00, 1'b1, 1'b1, 6'd2, 8'h00, 8'h04};
        tbl[11] = '{8'h00, 1'b1, 1'b0, 6'd0, 8'h00, 8'h00};
        for (int i = 0; i < 12; i++) begin
            apply(1'b1, tbl[i].rv, 8'h00, tbl[i].rdy, tbl[i].respv, tbl[i].tag);
            check("tbl_ready", 64'(req_ready), 64'(tbl[i].exp_ready));
            check("tbl_mask", 64'(warp_stall_mask), 64'(tbl[i].exp_mask));
            commit();
        end

        // Round-robin over warps 0,1,3 until every one is at MAX_OUTSTANDING.
        for (int i = 0; i < 14; i++) step(1'b1, 8'h0B, 8'h0A, 1'b1, 1'b0, 6'd0);
        apply(1'b1, 8'h0B, 8'h0A, 1'b1, 1'b0, 6'd0);
        check("rr_full_mask", 64'(warp_stall_mask), 64'(8'h0B));
        check("rr_full_valid", 64'(mem_req_valid), 64'(0));
        check("rr_full_ready", 64'(req_ready), 64'(0));
        commit();
        for (int k = 0; k < MAXO; k++) begin
            step(1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 6'd0);
            step(1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 6'd1);
            step(1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 6'd3);
        end

        // Response path: three grants to warp 1, three responses back.
        for (int i = 0; i < 3; i++) step(1'b1, 8'h02, 8'h00, 1'b1, 1'b0, 6'd0);
        step(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 6'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 6'd1);
        apply(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 6'd0);
        check("resp_mask1_clear", 64'(warp_stall_mask[1]), 64'(0));
        check("resp_no_err", 64'(err_underflow), 64'(0));
        commit();

        // Same-cycle grant and response on warp 4 with counter 1.
        step(1'b1, 8'h10, 8'h10, 1'b1, 1'b0, 6'd0);
        step(1'b1, 8'h10, 8'h10, 1'b1, 1'b1, 6'd4);
        apply(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 6'd0);
        check("net0_no_stall", 64'(stall_valid), 64'(0));
        check("net0_mask4", 64'(warp_stall_mask[4]), 64'(1));
        commit();
        step(1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 6'd4);

        // Response for tag 6 with nothing outstanding: sticky underflow.
        step(1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 6'd6);
        apply(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 6'd0);
        check("underflow_set", 64'(err_underflow), 64'(1));
        commit();
        for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 6'd0);
        apply(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 6'd0);
        check("underflow_sticky", 64'(err_underflow), 64'(1));
        commit();

        // Reset mid-operation with a held request and warps 0 and 7 outstanding.
        step(1'b1, 8'h81, 8'h00, 1'b1, 1'b0, 6'd0);
        step(1'b1, 8'h81, 8'h00, 1'b1, 1'b0, 6'd0);
        step(1'b1, 8'h81, 8'h00, 1'b0, 1'b0, 6'd0);
        step(1'b0, 8'h81, 8'h00, 1'b0, 1'b0, 6'd0);
        apply(1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 6'd0);
        check("post_rst_valid", 64'(mem_req_valid), 64'(0));
        check("post_rst_mask", 64'(warp_stall_mask), 64'(0));
        check("post_rst_err", 64'(err_underflow), 64'(0));
        check("post_rst_stall", 64'(stall_valid), 64'(0));
        check("post_rst_grant", 64'(req_ready), 64'(8'h01));
        commit();
        step(1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 6'd7);
        apply(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 6'd0);
        check("late_resp_err", 64'(err_underflow), 64'(1));
        commit();

        // Random traffic, including out-of-range tags and occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) != 0), NW'($urandom()), NW'($urandom()),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1), 6'($urandom_range(0, 9)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/warp_mem_arbiter.md
Name: warp_mem_arbiter

Overview:
- Shares the single memory request port between all warps in the SM.
- Each cycle, round-robin arbitrates among warps raising a load/store request and registers the winner onto the memory port.
- Tracks outstanding requests per warp and routes responses back by tag.
- Drives the per-warp memory stall mask consumed by warp_scheduler, so warps waiting on memory are not issued.

Parameters:
NUM_WARPS, 8, number of warps (2..64)
MAX_OUTSTANDING, 4, maximum in-flight requests per warp (1..15)
ADDR_W, 32, memory address width

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
req_valid  input  NUM_WARPS  per-warp request pending
req_addr  input  NUM_WARPS*ADDR_W  packed per-warp address; warp w at [w*ADDR_W +: ADDR_W]
req_write  input  NUM_WARPS  per-warp write flag
req_ready  output  NUM_WARPS  one-hot grant; request accepted this cycle
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  ADDR_W  request address
mem_req_write  output  1  request write flag
mem_req_tag  output  6  issuing warp id
mem_resp_valid  input  1  memory response valid (always accepted)
mem_resp_tag  input  6  warp id of response
resp_valid  output  1  registered response forward
resp_warp_id  output  6  warp id of forwarded response
warp_stall_mask  output  NUM_WARPS  bit w = 1 while warp w has outstanding requests > 0
stall_valid  output  1  one-cycle pulse when a warp newly enters stall
stall_warp_id  output  6  warp id for stall_valid
err_underflow  output  1  sticky: response received for a warp with 0 outstanding

Behaviour:
- Reset (clk, rst_n synchronous active-low) clears the following: all outputs 0, all outstanding counters 0, round-robin pointer 0, err_underflow 0. Reset mid-transaction discards the held request and all counters; in-flight responses arriving afterwards set err_underflow.
- Eligibility: warp w is eligible when req_valid[w]=1 and outstanding[w] < MAX_OUTSTANDING.
- Slot free: slot_free = !mem_req_valid || mem_req_ready.
- Grant, combinational in cycle t:
  - If slot_free and any warp is eligible, req_ready has exactly one bit set.
  - The winner is the first eligible warp searching upward from rr_ptr, with wrap-around modulo NUM_WARPS.
  - Otherwise req_ready = 0.
- On grant of warp w at edge t:
  - mem_req_valid=1, mem_req_addr=req_addr[w], mem_req_write=req_write[w], mem_req_tag=w, all visible at t+1.
  - outstanding[w] increments.
  - rr_ptr = (w+1) mod NUM_WARPS.
- Memory port hold: while mem_req_valid=1 and mem_req_ready=0, the valid, addr, write and tag outputs hold stable and no grant is issued. If the slot is accepted with no new grant, mem_req_valid goes to 0 next cycle. Back-to-back grants are allowed every cycle while mem_req_ready=1.
- Response:
  - mem_resp_valid with tag t decrements outstanding[t].
  - resp_valid=1 and resp_warp_id=t one cycle later.
  - If outstanding[t]=0, or t >= NUM_WARPS, the counter is unchanged and err_underflow is set (sticky until reset); the response is still forwarded.
- Simultaneous grant and response for the same warp: counter unchanged (net 0).
- Stall mask: warp_stall_mask is registered and reflects counters after the update, i.e. it asserts the cycle after the grant that takes the counter 0→1.
- Stall pulse: stall_valid pulses for one cycle with stall_warp_id=w on a 0→1 counter transition. A 0→1 transition cannot occur for two warps in one cycle.
- Counter width: clog2(MAX_OUTSTANDING+1) bits; saturation is never reached because grants are blocked at MAX_OUTSTANDING.

Test Plan:
- Single request: req_valid[2]=1, addr 0x1000, mem_req_ready=1 → req_ready=0x04 same cycle; next cycle mem_req_valid=1, addr 0x1000, tag 2, warp_stall_mask=0x04, stall_valid pulse id 2.
- Round-robin: req_valid=0x0B held, ready=1, MAX_OUTSTANDING=4 → tags issued 0,1,3,0,1,3,...; each warp blocked after 4 grants; mem_req_valid drops once all are at max.
- Backpressure: grant warp 5, mem_req_ready=0 for 4 cycles → addr/tag stable for 4 cycles, req_ready=0 throughout; ready=1 → next eligible warp granted in the same cycle.
- Response path: 3 grants to warp 1, then 3 responses tag 1 → resp_valid ×3 with id 1; warp_stall_mask[1] clears after the third; err_underflow stays 0.
- Boundary: grant and response for warp 4 in the same cycle with counter=1 → counter stays 1, mask bit stays set, no stall_valid; a response for tag 6 with counter 0 → err_underflow=1 and sticky.
- Reset mid-operation: warp 0 and warp 7 outstanding with mem_req_valid held, then assert rst_n=0 for 1 cycle → all outputs and the mask are 0; the next grant starts from warp 0.
